multi_debounce: RTL

MULTI_DEBOUNCE -- requirements
Module: multi_debounce

---
 rtl/multi_debounce.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/multi_debounce.sv
// Multi-channel button debouncer: two-flop synchronizer, four-state debounce FSM per channel,
// one-cycle press/release pulses and an optional long-press level.
module multi_debounce #(
    parameter int CHANNELS        = 4,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int CNT_WIDTH       = 10,
    parameter int ACTIVE_LOW      = 1,
    parameter int LONG_CYCLES     = 0,
    parameter int LONG_WIDTH      = 16
) (
    input  logic                m_clock,
    input  logic                m_reset_n,
    input  logic [CHANNELS-1:0] m_button,
    output logic [CHANNELS-1:0] m_state,
    output logic [CHANNELS-1:0] m_press,
    output logic [CHANNELS-1:0] m_release,
    output logic [CHANNELS-1:0] m_long
);

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_PEND   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_PEND = 2'd3
    } state_t;

    localparam logic                  IDLE_LEVEL = (ACTIVE_LOW != 0);
    localparam logic                  SINGLE     = (DEBOUNCE_CYCLES == 1);
    localparam logic                  LONG_EN    = (LONG_CYCLES != 0);
    localparam logic [CNT_WIDTH-1:0]  CNT_LAST   = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE    = CNT_WIDTH'(1);
    localparam logic [LONG_WIDTH-1:0] LONG_MAX   = LONG_WIDTH'(LONG_CYCLES);

    logic [CHANNELS-1:0] sync1_q;
    logic [CHANNELS-1:0] sync2_q;

    // Synchronizer idles at the released pin level so reset never looks like a press.
    always_ff @(posedge m_clock or negedge m_reset_n) begin
        if (!m_reset_n) begin
            sync1_q <= {CHANNELS{IDLE_LEVEL}};
            sync2_q <= {CHANNELS{IDLE_LEVEL}};
        end else begin
            sync1_q <= m_button;
            sync2_q <= sync1_q;
        end
    end

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        state_t                state_q, state_d;
        logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
        logic [LONG_WIDTH-1:0] long_q, long_d;
        logic                  press_q, press_d;
        logic                  release_q, release_d;
        logic                  held_d;
        logic                  sample;

        assign sample = sync2_q[gi] ^ IDLE_LEVEL;

        always_ff @(posedge m_clock or negedge m_reset_n) begin
            if (!m_reset_n) begin
                state_q   <= RELEASED;
                cnt_q     <= '0;
                long_q    <= '0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                long_q    <= long_d;
                press_q   <= press_d;
                release_q <= release_d;
            end
        end

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            case (state_q)
                RELEASED: begin
                    cnt_d = '0;
                    if (sample) begin
                        state_d = SINGLE ? PRESSED : PRESS_PEND;
                        cnt_d   = SINGLE ? '0 : CNT_ONE;
                    end
                end
                PRESS_PEND: begin
                    if (!sample) begin
                        state_d = RELEASED;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                PRESSED: begin
                    cnt_d = '0;
                    if (!sample) begin
                        state_d = SINGLE ? RELEASED : RELEASE_PEND;
                        cnt_d   = SINGLE ? '0 : CNT_ONE;
                    end
                end
                RELEASE_PEND: begin
                    if (sample) begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = RELEASED;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end
            endcase

            press_d   = (state_d == PRESSED) &&
                        ((state_q == RELEASED) || (state_q == PRESS_PEND));
            release_d = (state_d == RELEASED) &&
                        ((state_q == PRESSED) || (state_q == RELEASE_PEND));
            held_d    = (state_d == PRESSED) || (state_d == RELEASE_PEND);

            // A rejected release glitch keeps the press (and its duration) alive.
            if (press_d || !held_d) begin
                long_d = '0;
            end else if (long_q != LONG_MAX) begin
                long_d = long_q + 1'b1;
            end else begin
                long_d = long_q;
            end
        end

        assign m_state[gi]   = (state_q == PRESSED) || (state_q == RELEASE_PEND);
        assign m_press[gi]   = press_q;
        assign m_release[gi] = release_q;
        assign m_long[gi]    = LONG_EN && m_state[gi] && (long_q == LONG_MAX);
    end

endmodule
